// File: rtl/fir_reload_filter.sv
// Single-MAC time-multiplexed FIR with a shadow/active coefficient bank pair.
// One result per accepted sample; coefficient swaps happen only while idle.
module fir_reload_filter #(
   parameter int unsigned NUM_TAPS  = 23,
   parameter int unsigned DATA_W    = 24,
   parameter int unsigned COEF_W    = 16,
   parameter int unsigned ACC_W     = 48,
   parameter int unsigned OUT_SHIFT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              nd,
   input  logic [DATA_W-1:0] din,
   output logic              rfd,
   output logic              rdy,
   output logic [DATA_W-1:0] dout,
   input  logic              coef_ld,
   input  logic              coef_we,
   input  logic [COEF_W-1:0] coef_din
);

   localparam int unsigned CNT_W  = $clog2(NUM_TAPS + 1);
   localparam int unsigned PROD_W = DATA_W + COEF_W;

   typedef enum logic {IDLE, MAC} state_t;

   state_t state, next_state;
   logic [CNT_W-1:0]         cnt;
   logic [CNT_W-1:0]         tap_idx;
   logic [CNT_W-1:0]         wr_ptr;
   logic                     swap_pend;
   logic                     accept, mac_en, done;
   logic signed [DATA_W-1:0] dline    [NUM_TAPS];
   logic signed [COEF_W-1:0] active_h [NUM_TAPS];
   logic signed [COEF_W-1:0] shadow_h [NUM_TAPS];
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  shifted;
   logic signed [PROD_W-1:0] prod;
   logic [DATA_W-1:0]        sat_val;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // cnt == NUM_TAPS is the final cycle that writes the result
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (nd) next_state = MAC;
         MAC:     if (cnt == CNT_W'(NUM_TAPS)) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      accept = 1'b0;
      mac_en = 1'b0;
      done   = 1'b0;
      case (state)
         IDLE: accept = nd;
         MAC: begin
            if (cnt == CNT_W'(NUM_TAPS)) done   = 1'b1;
            else                         mac_en = 1'b1;
         end
         default: ;
      endcase
   end

   assign tap_idx = (cnt < CNT_W'(NUM_TAPS)) ? cnt : '0;
   assign prod    = PROD_W'(dline[tap_idx]) * PROD_W'(active_h[tap_idx]);
   assign shifted = acc >>> OUT_SHIFT;

   // Clamp when the bits above the output sign bit are not a pure sign extension
   always_comb begin
      if ((&shifted[ACC_W-1:DATA_W-1]) || !(|shifted[ACC_W-1:DATA_W-1]))
         sat_val = shifted[DATA_W-1:0];
      else if (shifted[ACC_W-1])
         sat_val = {1'b1, {(DATA_W-1){1'b0}}};
      else
         sat_val = {1'b0, {(DATA_W-1){1'b1}}};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         acc  <= '0;
         rfd  <= 1'b1;
         rdy  <= 1'b0;
         dout <= '0;
         for (int i = 0; i < NUM_TAPS; i++) dline[i] <= '0;
      end else begin
         rdy <= done;
         rfd <= (next_state == IDLE);
         if (accept) begin
            for (int i = NUM_TAPS - 1; i > 0; i--) dline[i] <= dline[i-1];
            dline[0] <= din;
            cnt      <= '0;
            acc      <= '0;
         end
         if (mac_en) begin
            acc <= acc + ACC_W'(prod);
            cnt <= cnt + CNT_W'(1);
         end
         if (done) dout <= sat_val;
      end
   end

   // Shadow writes; a complete set is copied to the active bank once idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         swap_pend <= 1'b0;
         for (int i = 0; i < NUM_TAPS; i++) begin
            shadow_h[i] <= '0;
            active_h[i] <= '0;
         end
      end else begin
         if (coef_ld) begin
            wr_ptr    <= '0;
            swap_pend <= 1'b0;
         end else if (coef_we && (wr_ptr < CNT_W'(NUM_TAPS))) begin
            shadow_h[wr_ptr] <= coef_din;
            wr_ptr           <= wr_ptr + CNT_W'(1);
            if (wr_ptr == CNT_W'(NUM_TAPS - 1)) swap_pend <= 1'b1;
         end
         if ((state == IDLE) && swap_pend && !coef_ld) begin
            active_h  <= shadow_h;
            swap_pend <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fir_reload_filter.sv
// Directed bench for fir_reload_filter: reset state, impulse, saturation,
// sample dropping, coefficient reload timing and mid-MAC reset.
module tb_fir_reload_filter;

   localparam int unsigned NT = 23;

   typedef struct {
      logic [23:0] din;
      logic [23:0] exp;
      bit          chk;
   } vec_t;

   logic        clk, rst, nd, rfd, rdy, coef_ld, coef_we;
   logic [23:0] din, dout;
   logic [15:0] coef_din;
   logic [15:0] coef_buf [NT];
   logic [23:0] y;
   int          lat;
   int          n_chk, n_fail;
   vec_t        t2 [NT];
   vec_t        t3 [2*NT];

   fir_reload_filter dut (
      .clk(clk), .rst(rst), .nd(nd), .din(din), .rfd(rfd), .rdy(rdy), .dout(dout),
      .coef_ld(coef_ld), .coef_we(coef_we), .coef_din(coef_din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; nd = 1'b0; din = '0; coef_ld = 1'b0; coef_we = 1'b0; coef_din = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic load_coefs();
      coef_ld = 1'b1;
      @(negedge clk);
      coef_ld = 1'b0;
      for (int i = 0; i < NT; i++) begin
         coef_we = 1'b1; coef_din = coef_buf[i];
         @(negedge clk);
      end
      coef_we = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_sample(input logic [23:0] d, output logic [23:0] res, output int latency);
      int n = 0;
      while (!rfd && n < 100) begin @(negedge clk); n++; end
      if (!rfd) begin
         n_chk++; n_fail++;
         $display("FAIL rfd_wait: got 0 expected 1");
      end
      nd = 1'b1; din = d;
      @(negedge clk);
      nd = 1'b0;
      latency = 1;
      while (!rdy && latency < 60) begin @(negedge clk); latency++; end
      if (!rdy) begin
         n_chk++; n_fail++;
         $display("FAIL rdy_wait: got 0 expected 1");
      end
      latency = latency - 1;
      res = dout;
   endtask

   initial begin
      logic [23:0] y1;
      int rdy_cnt, first_rdy;
      bit rdy_seen;
      n_chk = 0; n_fail = 0;

      for (int i = 0; i < NT; i++) begin
         t2[i].din = (i == 0) ? 24'd1000 : 24'd0;
         t2[i].exp = (i == 3) ? 24'd500 : 24'd0;
         t2[i].chk = 1'b1;
      end
      for (int i = 0; i < 2*NT; i++) begin
         t3[i].din = (i < NT) ? 24'h7FFFFF : 24'h800000;
         t3[i].exp = (i < 2*NT - 1) ? 24'h7FFFFF : 24'h800000;
         t3[i].chk = (i == 0) || (i == NT - 1) || (i == NT) || (i == 2*NT - 1);
      end
      t3[0].exp = 24'h7FFEFF;

      // reset state and zero-coefficient latency
      do_reset();
      check("reset_rfd", rfd, 1);
      check("reset_rdy", rdy, 0);
      check("reset_dout", dout, 0);
      do_sample(24'd1000, y, lat);
      check("t1_latency", lat, 24);
      check("t1_dout", y, 0);
      check("t1_rfd_with_rdy", rfd, 1);
      @(negedge clk);
      check("t1_rdy_one_cycle", rdy, 0);

      // impulse through h[3] = 0.5
      do_reset();
      for (int i = 0; i < NT; i++) coef_buf[i] = 16'd0;
      coef_buf[3] = 16'd16384;
      load_coefs();
      for (int i = 0; i < NT; i++) begin
         do_sample(t2[i].din, y, lat);
         if (t2[i].chk) check($sformatf("t2_out%0d", i), y, t2[i].exp);
      end

      // saturation both ways
      do_reset();
      for (int i = 0; i < NT; i++) coef_buf[i] = 16'd32767;
      load_coefs();
      for (int i = 0; i < 2*NT; i++) begin
         do_sample(t3[i].din, y, lat);
         if (t3[i].chk) check($sformatf("t3_out%0d", i), y, t3[i].exp);
      end

      // nd held high: accepted every 25 clocks, no rdy for dropped samples
      do_reset();
      rdy_cnt = 0; first_rdy = -1;
      nd = 1'b1; din = 24'd5;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rdy) begin
            rdy_cnt++;
            if (first_rdy < 0) first_rdy = i;
         end
      end
      nd = 1'b0;
      check("t4_rdy_count", rdy_cnt, 4);
      check("t4_first_rdy", first_rdy, 24);

      // reload while busy: in-flight result keeps the old set
      do_reset();
      for (int i = 0; i < NT; i++) coef_buf[i] = 16'd1024;
      load_coefs();
      for (int i = 0; i < NT - 1; i++) do_sample(24'd4000, y, lat);
      for (int i = 0; i < NT; i++) coef_buf[i] = 16'd0;
      coef_buf[0] = 16'd32767;
      y1 = '0;
      fork
         load_coefs();
         begin
            repeat (5) @(negedge clk);
            do_sample(24'd4000, y1, lat);
         end
      join
      check("t5_old_set", y1, 2875);
      do_sample(24'hFFF800, y, lat);
      check("t5_new_set", y, 24'hFFF800);
      coef_ld = 1'b1;
      @(negedge clk);
      coef_ld = 1'b0;
      for (int i = 0; i < 5; i++) begin
         coef_we = 1'b1; coef_din = 16'd0;
         @(negedge clk);
      end
      coef_we = 1'b0;
      repeat (3) @(negedge clk);
      do_sample(24'd1000, y, lat);
      check("t5_partial_reload", y, 999);

      // reset mid-MAC aborts the result and clears coefficients
      do_reset();
      for (int i = 0; i < NT; i++) coef_buf[i] = 16'd0;
      coef_buf[0] = 16'd32767;
      load_coefs();
      nd = 1'b1; din = 24'd1000;
      @(negedge clk);
      nd = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #6 rst = 1'b0;
      rdy_seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (rdy) rdy_seen = 1'b1;
      end
      check("t6_no_rdy", rdy_seen, 0);
      check("t6_dout", dout, 0);
      check("t6_rfd", rfd, 1);
      do_sample(24'd1000, y, lat);
      check("t6_coefs_cleared", y, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
